// File: rtl/cpu_bus_pkg.sv
// Shared types for the UART CPU-bus master: access FSM states and the queued request format.
package cpu_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } bus_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_req_fifo.sv
// Request queue for cpu_bus_master: DEPTH entries (power of two), registered full/empty flags.
module bus_req_fifo
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  bus_req_t wdata_i,
  input  logic     pop_i,
  output bus_req_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

  bus_req_t      mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push) count_d = count_d + 1'b1;
    if (do_pop)  count_d = count_d - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Flags are computed from the next count so they stay pure registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_L);
      empty_q <= (count_d == '0);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/cpu_bus_master.sv
// Queued master for the UART's asynchronous-strobe CPU bus; phases SETUP/STROBE/HOLD per access,
// returns read data and synchronises the UART interrupt.
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] AddrBus,
  output logic              n_ChipSelect,
  output logic              n_rd,
  output logic              n_we,
  output logic [DATA_W-1:0] DataBusI,
  input  logic [DATA_W-1:0] DataBusO,
  input  logic              p_IrqSig,
  output logic              irq_level,
  output logic              irq_rise
);

  localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] SETUP_L  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_L = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_L   = CW'(HOLD_CYC - 1);

  bus_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bus_req_t    acc_q, acc_d, head, req_in;
  logic        fifo_full, fifo_empty, pop, last, rd_sample;

  logic              cs_n_q, rd_n_q, we_n_q, rsp_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
  logic              irq_meta_q, irq_level_q, irq_prev_q, irq_rise_q;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata};

  bus_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .wdata_i (req_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign last      = (cnt_q == '0);
  assign rd_sample = (state_q == STROBE) && last && !acc_q.write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        acc_d   = head;
        state_d = SETUP;
        cnt_d   = SETUP_L;
      end
      SETUP:  if (last) begin state_d = STROBE; cnt_d = STROBE_L; end
              else cnt_d = cnt_q - 1'b1;
      STROBE: if (last) begin state_d = HOLD; cnt_d = HOLD_L; end
              else cnt_d = cnt_q - 1'b1;
      HOLD:   if (last) state_d = IDLE;
              else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Bus pins are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      irq_meta_q  <= 1'b0;
      irq_level_q <= 1'b0;
      irq_prev_q  <= 1'b0;
      irq_rise_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      cs_n_q      <= (state_d == IDLE);
      rd_n_q      <= !((state_d == STROBE) && !acc_d.write);
      we_n_q      <= !((state_d == STROBE) && acc_d.write);
      if (state_d != IDLE) addr_q <= acc_d.addr;
      wdata_q     <= ((state_d != IDLE) && acc_d.write) ? acc_d.wdata : '0;
      rsp_valid_q <= rd_sample;
      if (rd_sample) rsp_rdata_q <= DataBusO;
      irq_meta_q  <= p_IrqSig;
      irq_level_q <= irq_meta_q;
      irq_prev_q  <= irq_level_q;
      irq_rise_q  <= irq_level_q && !irq_prev_q;
    end
  end

  assign req_ready    = !fifo_full;
  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign AddrBus      = addr_q;
  assign n_ChipSelect = cs_n_q;
  assign n_rd         = rd_n_q;
  assign n_we         = we_n_q;
  assign DataBusI     = wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign irq_level    = irq_level_q;
  assign irq_rise     = irq_rise_q;

endmodule
